// File: rtl/updown_counter_multi_if.sv
// Button/display bundle for the multi-digit up/down counter.
// The master side drives the conditioned buttons and the load bus; the slave
// side (the counter) returns the packed count, the segment patterns and the
// limit/wrap flags.
interface updown_counter_multi_if #(
  parameter int DIGITS = 2
);
  logic                  up;
  logic                  down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count;
  logic [7*DIGITS-1:0]   hex;
  logic                  wrap;
  logic                  at_max;
  logic                  at_min;

  modport master (
    output up, down, load, load_value,
    input  count, hex, wrap, at_max, at_min
  );

  modport slave (
    input  up, down, load, load_value,
    output count, hex, wrap, at_max, at_min
  );
endinterface

// File: rtl/updown_counter_multi.sv
// Multi-digit up/down counter with per-digit radix (BCD or hex), wrap or
// saturate at the limits, parallel load and hold-to-repeat stepping.
// Each digit drives one active-low 7-segment pattern ({g,f,e,d,c,b,a}).
module updown_counter_multi #(
  parameter int DIGITS        = 2,
  parameter int RADIX         = 10,
  parameter int SATURATE      = 0,
  parameter int BLANK_LZ      = 0,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  updown_counter_multi_if.slave bus
);

  localparam int          W       = 4 * DIGITS;
  localparam logic [3:0]  DMAX    = 4'(RADIX - 1);
  localparam logic [31:0] HOLD_LD = (HOLD_CYCLES > 0) ? 32'(HOLD_CYCLES - 1) : 32'd0;
  localparam logic [31:0] REP_LD  = (REPEAT_CYCLES > 0) ? 32'(REPEAT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  // All digits at RADIX-1: the top of the counting range.
  function automatic logic [W-1:0] max_value();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < DIGITS; k++) v[4*k +: 4] = DMAX;
    return v;
  endfunction

  localparam logic [W-1:0] MAX_VAL = max_value();

  // Digits that are not legal in the current radix are pinned to RADIX-1.
  function automatic logic [W-1:0] clamp_digits(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] > DMAX) r[4*k +: 4] = DMAX;
    return r;
  endfunction

  // Digit-wise increment with ripple carry.
  function automatic logic [W-1:0] inc_digits(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (v[4*k +: 4] == DMAX) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit-wise decrement with ripple borrow.
  function automatic logic [W-1:0] dec_digits(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = DMAX;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1011000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_t         r_state;
  logic [31:0]    r_timer;
  logic           r_dir_dn;
  logic           r_up_prev;
  logic           r_down_prev;
  logic [W-1:0]   r_count;
  logic           r_wrap;

  logic           w_dir_up;
  logic           w_dir_dn;
  logic           w_req_up;
  logic           w_req_dn;
  logic           w_held;
  logic           w_step;
  logic           w_step_dn;
  logic           w_at_max;
  logic           w_at_min;
  logic [7*DIGITS-1:0] w_hex;

  assign w_dir_up = bus.up & ~bus.down;
  assign w_dir_dn = bus.down & ~bus.up;
  assign w_req_up = w_dir_up & ~r_up_prev;
  assign w_req_dn = w_dir_dn & ~r_down_prev;
  // The direction latched at the first step is still the only one pressed.
  assign w_held   = r_dir_dn ? w_dir_dn : w_dir_up;
  assign w_at_max = (r_count == MAX_VAL);
  assign w_at_min = (r_count == '0);

  // Decide whether this edge performs a step and in which direction.
  always_comb begin
    w_step    = 1'b0;
    w_step_dn = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_up) begin
          w_step = 1'b1;
        end else if (w_req_dn) begin
          w_step    = 1'b1;
          w_step_dn = 1'b1;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (w_held && (r_timer == 32'd0)) begin
          w_step    = 1'b1;
          w_step_dn = r_dir_dn;
        end
      end
      default: ;
    endcase
  end

  // Button history is sampled even in reset so a held button needs a re-press.
  always_ff @(posedge CLOCK_50) begin
    r_up_prev   <= bus.up;
    r_down_prev <= bus.down;
  end

  // Hold/repeat FSM plus the count and wrap registers it steps.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_timer  <= 32'd0;
      r_dir_dn <= 1'b0;
      r_count  <= '0;
      r_wrap   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_step) begin
            r_dir_dn <= w_step_dn;
            if (HOLD_CYCLES != 0) begin
              r_timer <= HOLD_LD;
              r_state <= S_DELAY;
            end
          end
        end
        S_DELAY, S_REPEAT: begin
          if (!w_held) begin
            r_state <= S_IDLE;
          end else if (r_timer == 32'd0) begin
            r_timer <= REP_LD;
            r_state <= S_REPEAT;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Load overrides a step, but the timing above still advances.
      r_wrap <= 1'b0;
      if (bus.load) begin
        r_count <= clamp_digits(bus.load_value);
      end else if (w_step) begin
        if (!w_step_dn) begin
          if (!w_at_max) begin
            r_count <= inc_digits(r_count);
          end else if (SATURATE == 0) begin
            r_count <= '0;
            r_wrap  <= 1'b1;
          end
        end else begin
          if (!w_at_min) begin
            r_count <= dec_digits(r_count);
          end else if (SATURATE == 0) begin
            r_count <= MAX_VAL;
            r_wrap  <= 1'b1;
          end
        end
      end
    end
  end

  // Segment decode with optional blanking of leading zero digits above digit 0.
  always_comb begin
    logic hi_zero;
    w_hex   = '0;
    hi_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (r_count[4*k +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (k > 0) && hi_zero)
        w_hex[7*k +: 7] = 7'b1111111;
      else
        w_hex[7*k +: 7] = seg7(r_count[4*k +: 4]);
    end
  end

  assign bus.count  = r_count;
  assign bus.hex    = w_hex;
  assign bus.wrap   = r_wrap;
  assign bus.at_max = w_at_max;
  assign bus.at_min = w_at_min;

endmodule

// File: tb/tb_updown_counter_multi.sv
// Bench for updown_counter_multi: four configurations share one stimulus
// stream and are compared every cycle against a value-level reference model,
// plus a directed vector table and hand-written hold/reset sequences.
module tb_updown_counter_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, load;
  logic [7:0] lv;

  always #10 clk = ~clk;

  updown_counter_multi_if #(.DIGITS(2)) ia ();
  updown_counter_multi_if #(.DIGITS(2)) ib ();
  updown_counter_multi_if #(.DIGITS(2)) ic ();
  updown_counter_multi_if #(.DIGITS(1)) id ();

  assign ia.up = up;  assign ia.down = down;  assign ia.load = load;  assign ia.load_value = lv;
  assign ib.up = up;  assign ib.down = down;  assign ib.load = load;  assign ib.load_value = lv;
  assign ic.up = up;  assign ic.down = down;  assign ic.load = load;  assign ic.load_value = lv;
  assign id.up = up;  assign id.down = down;  assign id.load = load;  assign id.load_value = lv[3:0];

  updown_counter_multi #(.DIGITS(2), .RADIX(10), .SATURATE(0), .BLANK_LZ(0),
    .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_a (.CLOCK_50(clk), .reset(rst), .bus(ia));
  updown_counter_multi #(.DIGITS(2), .RADIX(10), .SATURATE(1), .BLANK_LZ(0),
    .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_b (.CLOCK_50(clk), .reset(rst), .bus(ib));
  updown_counter_multi #(.DIGITS(2), .RADIX(10), .SATURATE(0), .BLANK_LZ(1),
    .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_c (.CLOCK_50(clk), .reset(rst), .bus(ic));
  updown_counter_multi #(.DIGITS(1), .RADIX(16), .SATURATE(0), .BLANK_LZ(0),
    .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_d (.CLOCK_50(clk), .reset(rst), .bus(id));

  typedef struct {
    int digits; int radix; int sat; int blank; int hold; int rep;
  } cfg_t;

  // Reference state: numeric value, wrap flag, active held direction
  // (0 none, 1 up, 2 down) and cycles elapsed since its first step.
  typedef struct {
    int v; bit wrap; int act; int n; bit up_p; bit dn_p;
  } mdl_t;

  typedef struct {
    bit u; bit d; bit ld; logic [7:0] lv; logic [7:0] ec; bit ew;
  } vec_t;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  cfg_t C [4];
  mdl_t M [4];
  vec_t tbl [17];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int ipow(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, cfg_t c, bit u, bit d, bit ld,
                                 logic [7:0] lval, bit rs);
    mdl_t r;
    int   top, want, nib, val;
    bit   st, edge_req;
    r = m;
    r.up_p = u;
    r.dn_p = d;
    if (rs) begin
      r.v = 0; r.wrap = 1'b0; r.act = 0; r.n = 0;
      return r;
    end
    top  = ipow(c.radix, c.digits) - 1;
    want = (u && !d) ? 1 : ((d && !u) ? 2 : 0);
    st   = 1'b0;
    if (m.act != 0) begin
      if (want == m.act) begin
        r.n = m.n + 1;
        st  = (r.n == c.hold) || (r.n > c.hold && ((r.n - c.hold) % c.rep) == 0);
      end else begin
        r.act = 0;
      end
    end else begin
      edge_req = (want == 1 && !m.up_p) || (want == 2 && !m.dn_p);
      if (edge_req) begin
        st    = 1'b1;
        r.act = (c.hold == 0) ? 0 : want;
        r.n   = 0;
      end
    end
    r.wrap = 1'b0;
    if (ld) begin
      val = 0;
      for (int k = 0; k < c.digits; k++) begin
        nib = int'(lval[4*k +: 4]);
        if (nib >= c.radix) nib = c.radix - 1;
        val = val + nib * ipow(c.radix, k);
      end
      r.v = val;
    end else if (st) begin
      if (want == 1) begin
        if (m.v < top) r.v = m.v + 1;
        else if (c.sat == 0) begin r.v = 0; r.wrap = 1'b1; end
      end else begin
        if (m.v > 0) r.v = m.v - 1;
        else if (c.sat == 0) begin r.v = top; r.wrap = 1'b1; end
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] ecount(int v, cfg_t c);
    logic [63:0] r = '0;
    for (int k = 0; k < c.digits; k++)
      r[4*k +: 4] = 4'((v / ipow(c.radix, k)) % c.radix);
    return r;
  endfunction

  function automatic logic [63:0] ehex(int v, cfg_t c);
    logic [63:0] r = '0;
    int dg;
    for (int k = 0; k < c.digits; k++) begin
      dg = (v / ipow(c.radix, k)) % c.radix;
      if (c.blank != 0 && k > 0 && v < ipow(c.radix, k)) r[7*k +: 7] = 7'b1111111;
      else r[7*k +: 7] = SEG[dg];
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(string nm, int i, logic [63:0] cnt, logic [63:0] hx,
                          logic w, logic mx, logic mn);
    int top;
    top = ipow(C[i].radix, C[i].digits) - 1;
    chk({nm, ".count"},  cnt, ecount(M[i].v, C[i]));
    chk({nm, ".hex"},    hx,  ehex(M[i].v, C[i]));
    chk({nm, ".wrap"},   64'(w),  64'(M[i].wrap));
    chk({nm, ".at_max"}, 64'(mx), 64'(M[i].v == top));
    chk({nm, ".at_min"}, 64'(mn), 64'(M[i].v == 0));
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++) M[i] = mstep(M[i], C[i], up, down, load, lv, rst);
    #1;
    chk_inst("A", 0, 64'(ia.count), 64'(ia.hex), ia.wrap, ia.at_max, ia.at_min);
    chk_inst("B", 1, 64'(ib.count), 64'(ib.hex), ib.wrap, ib.at_max, ib.at_min);
    chk_inst("C", 2, 64'(ic.count), 64'(ic.hex), ic.wrap, ic.at_max, ic.at_min);
    chk_inst("D", 3, 64'(id.count), 64'(id.hex), id.wrap, id.at_max, id.at_min);
  endtask

  task automatic drive(bit u, bit d, bit ld, logic [7:0] l);
    up = u; down = d; load = ld; lv = l;
  endtask

  function automatic vec_t mkv(bit u, bit d, bit ld, logic [7:0] l, logic [7:0] ec, bit ew);
    vec_t v;
    v.u = u; v.d = d; v.ld = ld; v.lv = l; v.ec = ec; v.ew = ew;
    return v;
  endfunction

  initial begin
    C[0] = '{2, 10, 0, 0, 4, 2};
    C[1] = '{2, 10, 1, 0, 4, 2};
    C[2] = '{2, 10, 0, 1, 4, 2};
    C[3] = '{1, 16, 0, 0, 4, 2};
    for (int i = 0; i < 4; i++) M[i] = '{0, 1'b0, 0, 0, 1'b0, 1'b0};

    tbl[0]  = mkv(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
    tbl[1]  = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
    tbl[2]  = mkv(1'b0, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0);
    tbl[3]  = mkv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tbl[4]  = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tbl[5]  = mkv(1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0);
    tbl[6]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0);
    tbl[7]  = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0);
    tbl[8]  = mkv(1'b0, 1'b0, 1'b1, 8'hAF, 8'h99, 1'b0);
    tbl[9]  = mkv(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    tbl[10] = mkv(1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1);
    tbl[11] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0);
    tbl[12] = mkv(1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0);
    tbl[13] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0);
    tbl[14] = mkv(1'b0, 1'b0, 1'b1, 8'h3C, 8'h39, 1'b0);
    tbl[15] = mkv(1'b1, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0);
    tbl[16] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 1'b0);

    // Reset state
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    chk("reset.A.count", 64'(ia.count), 64'h00);
    chk("reset.A.hex",   64'(ia.hex),   64'({7'b1000000, 7'b1000000}));
    chk("reset.C.hex",   64'(ic.hex),   64'({7'b1111111, 7'b1000000}));
    chk("reset.A.wrap",  64'(ia.wrap),  64'd0);
    rst = 1'b0;

    // Directed table on configuration A
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].u, tbl[i].d, tbl[i].ld, tbl[i].lv);
      tick();
      chk($sformatf("tbl%0d.count", i), 64'(ia.count), 64'(tbl[i].ec));
      chk($sformatf("tbl%0d.wrap", i),  64'(ia.wrap),  64'(tbl[i].ew));
      if (i == 0) begin
        chk("first_up.hex0", 64'(ia.hex[6:0]),  64'(7'b1111001));
        chk("first_up.hex1", 64'(ia.hex[13:7]), 64'(7'b1000000));
      end
      if (i == 3) begin
        chk("sat.B.count", 64'(ib.count), 64'h99);
        chk("sat.B.wrap",  64'(ib.wrap),  64'd0);
      end
    end

    // Blanking on C, hex wrap on D
    drive(1'b0, 1'b0, 1'b1, 8'h07);
    tick();
    chk("blank.C.hex1", 64'(ic.hex[13:7]), 64'(7'b1111111));
    chk("blank.C.hex0", 64'(ic.hex[6:0]),  64'(7'b1011000));
    drive(1'b0, 1'b0, 1'b1, 8'h0F);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("hex16.D.count", 64'(id.count), 64'h0);
    chk("hex16.D.wrap",  64'(id.wrap),  64'd1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("hex16.D.wrap_end", 64'(id.wrap), 64'd0);

    // Hold up 12 cycles from zero: steps at E0, +4, +6, +8, +10
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("hold12.A.count", 64'(ia.count), 64'h05);

    // Both held: no change
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) tick();
    chk("both.A.count", 64'(ia.count), 64'h05);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    // Reset in REPEAT with up still held
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) tick();
    chk("rpt.A.count", 64'(ia.count), 64'h03);
    rst = 1'b1;
    tick();
    chk("rst_hold.A.count", 64'(ia.count), 64'h00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_held.A.count", 64'(ia.count), 64'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("repress.A.count", 64'(ia.count), 64'h01);

    // Randomized button activity checked against the model every cycle
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) up   = ~up;
      if ($urandom_range(0, 9) == 0) down = ~down;
      load = ($urandom_range(0, 29) == 0);
      lv   = 8'($urandom);
      rst  = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
